sseg_scan_decoder: RTL and testbench
====================================

Name: sseg_scan_decoder

Overview:
- Receive-side monitor for the multiplexed seven-segment display bus: samples segment lines and digit anodes, and waits for each digit to dwell stably.
- Inverts the team's segment encoding table back to a 4-bit hex nibble.
- Reassembles a full N_DIGITS-digit word and emits a one-cycle frame strobe once every digit position has been captured.
- Used for on-board self-check and bench loopback of the display path.

Parameters:
- N_DIGITS, 8, number of anode lines / digit slots (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (>=2).
- CNT_W, 3, width of the dwell counter; must hold STABLE_CYCLES-1.
- TIMEOUT_CYCLES, 65535, idle limit used only with SSEG_FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- sseg  in  7  segment lines, index 0 = segment a through 6 = segment g; active-low.
- an  in  N_DIGITS  anode selects; active-low, one-hot-low when a digit is lit.
- value  out  4*N_DIGITS  assembled word; nibble k = digit k (an[k]).
- err_mask  out  N_DIGITS  bit k set = digit k pattern was not a legal code in the last frame.
- frame_valid  out  1  one-cycle pulse when value/err_mask are updated.
- timeout  out  1  one-cycle pulse; constant 0 unless SSEG_FRAME_TIMEOUT_EN.

Behaviour:
- Reset values: value=0, err_mask=0, frame_valid=0, timeout=0.
  - Internal state: sample regs=all ones, dwell count=0, accepted flag=0, captured mask=0, shadow word=0, shadow err=0.
- Sampling: {an,sseg} is registered every cycle into a sample register.
  - Next sample equals previous: dwell counter increments, saturating at STABLE_CYCLES-1.
  - Otherwise: counter clears to 0 and the accepted flag clears.
- Acceptance occurs in the cycle where the counter reaches STABLE_CYCLES-1, accepted=0 and the sampled an has exactly one bit low (index k). On acceptance:
  - Set accepted=1, so one accept per dwell.
  - Decode sseg into shadow nibble k.
  - Set captured[k].
  - Write shadow err[k].
- Latency: the digit is accepted STABLE_CYCLES+1 clocks after the pattern first appears.
- Ignored an values: all-ones (blanking) and multi-low an never accept. They do not touch the captured mask.
- Decode table (sseg written a..g, nibble): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 1001000=C, 1000010=D, 0110000=E, 0010000=F.
  - Any other pattern, including 1111111: nibble=0, err=1.
- Frame completion: captured mask becomes all ones. In that same cycle:
  - value <= shadow word, including the digit just accepted.
  - err_mask <= shadow err.
  - frame_valid=1 for exactly one cycle.
  - Captured mask clears.
- Re-capture: the same digit accepted again before frame completion overwrites its shadow nibble; last write wins.
- Frame order is irrelevant.
- value/err_mask hold between frames.
- Reset mid-frame discards partial capture immediately (asynchronous).

Optional Feature:
- Macro SSEG_FRAME_TIMEOUT_EN.
- Defined: an idle counter clears on every acceptance and increments otherwise. On reaching TIMEOUT_CYCLES:
  - Captured mask and shadow err clear.
  - timeout pulses high for 1 cycle.
  - Counter restarts.
  - value/err_mask are untouched.
- Not defined: no idle counter; timeout tied to 0; partial frames persist indefinitely.

Test Plan:
- Reset: hold rst_n=0 with random bus activity -> value=0, err_mask=0, frame_valid=0 throughout; release -> no pulse until 8 digits are accepted.
- Encoder loopback: scan digits 0..7 showing hex 1,2,3,4,A,B,C,D, with an[k] low for 16 cycles each -> single frame_valid, value=32'hDCBA4321, err_mask=0.
- Glitch rejection: pattern held 3 cycles (STABLE_CYCLES=4), then changed -> no accept; held 4 cycles -> accept exactly once even if held 100 cycles.
- Illegal/blank: digit 5 shows 1111111, others show legal codes -> frame_valid with nibble 5=0, err_mask=8'b0010_0000. Blanking an=8'hFF between digits -> ignored, no accept.
- Overwrite and order: digits in order 7..0 with digit 3 shown twice (first 9, then E) -> value nibble 3=E, one frame_valid.
- SSEG_FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=100: capture 5 digits, then idle 100 cycles -> timeout pulse. A following 8-digit scan yields exactly one frame_valid with only the new data.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_decoder
// Purpose  : Receive-side monitor for a multiplexed seven-segment display bus.
//            Samples {an, sseg} every clock, waits for each lit digit to dwell
//            stably for STABLE_CYCLES samples, decodes the segment pattern back
//            to a hex nibble and reassembles an N_DIGITS-digit word. A one-cycle
//            frame_valid strobe is raised once every digit slot was captured.
// Ports    : clk         - system clock
//            rst_n       - asynchronous active-low reset
//            sseg[6:0]   - segment lines, bit 0 = a .. bit 6 = g, active-low
//            an[N-1:0]   - anode selects, active-low, one-hot-low when lit
//            value       - assembled word, nibble k = digit k
//            err_mask    - bit k set = digit k carried an illegal pattern
//            frame_valid - one-cycle pulse when value/err_mask update
//            timeout     - one-cycle idle-timeout pulse (0 unless enabled)
// Options  : define SSEG_FRAME_TIMEOUT_EN to drop partial frames after
//            TIMEOUT_CYCLES clocks without an accepted digit.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_decoder #(
  parameter int N_DIGITS       = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            sseg,
  input  logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] value,
  output logic [N_DIGITS-1:0]   err_mask,
  output logic                  frame_valid,
  output logic                  timeout
);

  localparam int                  c_idx_w   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    c_cnt_max = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] c_all     = {N_DIGITS{1'b1}};

  // Sample register holds {an, sseg}
  logic [N_DIGITS+6:0]   r_smp;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_acc;
  logic [N_DIGITS-1:0]   r_cap;
  logic [N_DIGITS-1:0]   r_serr;
  logic [4*N_DIGITS-1:0] r_shadow;

  logic                  w_same;
  logic [N_DIGITS-1:0]   w_an_low;
  logic                  w_onehot;
  logic [c_idx_w-1:0]    w_idx;
  logic [4:0]            w_dec;
  logic                  w_accept;
  logic [N_DIGITS-1:0]   w_cap_next;
  logic [N_DIGITS-1:0]   w_serr_next;
  logic [4*N_DIGITS-1:0] w_shadow_next;
  logic                  w_frame_done;
  logic                  w_to_fire;

  // Inverse of the segment encoding table. Literals are written {g,f,e,d,c,b,a}
  // (bit 6 down to bit 0), active-low. Result is {illegal, nibble}.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b1000000: f_decode = 5'h00;
      7'b1111001: f_decode = 5'h01;
      7'b0100100: f_decode = 5'h02;
      7'b0110000: f_decode = 5'h03;
      7'b0011001: f_decode = 5'h04;
      7'b0010010: f_decode = 5'h05;
      7'b0000010: f_decode = 5'h06;
      7'b1111000: f_decode = 5'h07;
      7'b0000000: f_decode = 5'h08;
      7'b0010000: f_decode = 5'h09;
      7'b0001000: f_decode = 5'h0A;
      7'b0000011: f_decode = 5'h0B;
      7'b0001001: f_decode = 5'h0C;
      7'b0100001: f_decode = 5'h0D;
      7'b0000110: f_decode = 5'h0E;
      7'b0000100: f_decode = 5'h0F;
      default:    f_decode = 5'h10;
    endcase
  endfunction

  assign w_same   = ({an, sseg} == r_smp);
  assign w_an_low = ~r_smp[N_DIGITS+6:7];
  // Exactly one anode low: non-zero and a power of two after inversion.
  assign w_onehot = (w_an_low != '0) &&
                    ((w_an_low & (w_an_low - N_DIGITS'(1))) == '0);
  assign w_dec    = f_decode(r_smp[6:0]);
  // r_acc limits acceptance to once per stable dwell.
  assign w_accept = (r_cnt == c_cnt_max) && !r_acc && w_onehot;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_an_low[i]) w_idx = c_idx_w'(i);
    end
  end

  always_comb begin
    w_cap_next    = r_cap;
    w_serr_next   = r_serr;
    w_shadow_next = r_shadow;
    if (w_accept) begin
      w_cap_next[w_idx]           = 1'b1;
      w_serr_next[w_idx]          = w_dec[4];
      w_shadow_next[4*w_idx +: 4] = w_dec[3:0];
    end
  end

  // The frame closes on the accept that fills the last slot, so the
  // published word already contains that digit.
  assign w_frame_done = w_accept && (w_cap_next == c_all);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp       <= '1;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_cap       <= '0;
      r_serr      <= '0;
      r_shadow    <= '0;
      value       <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
    end else begin
      r_smp <= {an, sseg};

      if (!w_same) begin
        r_cnt <= '0;
        r_acc <= 1'b0;
      end else begin
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
        if (w_accept)           r_acc <= 1'b1;
      end

      r_shadow    <= w_shadow_next;
      frame_valid <= w_frame_done;

      if (w_to_fire) begin
        r_cap  <= '0;
        r_serr <= '0;
      end else if (w_frame_done) begin
        r_cap    <= '0;
        r_serr   <= w_serr_next;
        value    <= w_shadow_next;
        err_mask <= w_serr_next;
      end else begin
        r_cap  <= w_cap_next;
        r_serr <= w_serr_next;
      end
    end
  end

`ifdef SSEG_FRAME_TIMEOUT_EN
  localparam int                  c_idle_w   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYCLES - 1);

  logic [c_idle_w-1:0] r_idle;

  // Fires on the TIMEOUT_CYCLES-th consecutive clock without an accept.
  assign w_to_fire = !w_accept && (r_idle == c_idle_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= w_to_fire;
      if (w_accept || w_to_fire) r_idle <= '0;
      else                       r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_to_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_decoder
// Purpose  : Self-checking bench for sseg_scan_decoder. A behavioural model
//            built on run lengths and a string segment table predicts outputs
//            every cycle; directed scans pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_decoder;

  localparam int N  = 8;
  localparam int S  = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  sseg;
  logic [7:0]  an;
  logic [31:0] value;
  logic [7:0]  err_mask;
  logic        frame_valid;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_fv     = 0;
  int n_to     = 0;

  sseg_scan_decoder #(
    .N_DIGITS      (N),
    .STABLE_CYCLES (S),
    .CNT_W         (3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sseg       (sseg),
    .an         (an),
    .value      (value),
    .err_mask   (err_mask),
    .frame_valid(frame_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Segment table, characters in order a..g ('0' = lit).
  string c_tbl [16] = '{"0000001", "1001111", "0010010", "0000110",
                        "1001100", "0100100", "0100000", "0001111",
                        "0000000", "0000100", "0001000", "1100000",
                        "1001000", "1000010", "0110000", "0010000"};

  function automatic logic [6:0] enc(input int n);
    string s;
    logic [6:0] r;
    s = c_tbl[n];
    for (int i = 0; i < 7; i++) r[i] = (s[i] == "1");
    return r;
  endfunction

  function automatic int dec(input logic [6:0] p);
    for (int n = 0; n < 16; n++) if (enc(n) == p) return n;
    return -1;
  endfunction

  function automatic logic [7:0] dig(input int k);
    return ~(8'(1) << k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_prev_an;
  logic [6:0]  m_prev_sseg;
  int          m_run;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_serr, m_cap;
  logic [31:0] m_value;
  logic [7:0]  m_err;
  logic        m_fv, m_to;
  int          m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_an = '1; m_prev_sseg = '1; m_run = 1;
      for (int j = 0; j < 8; j++) m_nib[j] = 4'h0;
      m_serr = '0; m_cap = '0; m_value = '0; m_err = '0;
      m_fv = 1'b0; m_to = 1'b0; m_idle = 0;
    end else begin : step
      bit acc;
      int k, d;
      acc  = (m_run == S) && ($countones(~m_prev_an) == 1);
      m_fv = 1'b0;
      m_to = 1'b0;
      if (acc) begin
        k = 0;
        for (int j = 0; j < 8; j++) if (!m_prev_an[j]) k = j;
        d = dec(m_prev_sseg);
        m_nib[k]  = (d < 0) ? 4'h0 : 4'(d);
        m_serr[k] = (d < 0);
        m_cap[k]  = 1'b1;
        if (m_cap == 8'hFF) begin
          for (int j = 0; j < 8; j++) m_value[4*j +: 4] = m_nib[j];
          m_err = m_serr;
          m_fv  = 1'b1;
          m_cap = '0;
        end
      end
`ifdef SSEG_FRAME_TIMEOUT_EN
      if (acc) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin
          m_idle = 0; m_to = 1'b1; m_cap = '0; m_serr = '0;
        end
      end
`endif
      if ({an, sseg} == {m_prev_an, m_prev_sseg}) begin
        if (m_run <= S) m_run++;
      end else m_run = 1;
      m_prev_an   = an;
      m_prev_sseg = sseg;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("value",       value,       m_value);
    chk("err_mask",    err_mask,    m_err);
    chk("frame_valid", frame_valid, m_fv);
    chk("timeout",     timeout,     m_to);
    if (frame_valid) n_fv++;
    if (timeout)     n_to++;
  end

  task automatic show(input logic [7:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  int f0, t0;
  int vals [8];

  initial begin
    an = '1; sseg = '1; rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held with bus activity
    repeat (20) begin
      @(negedge clk);
      an = 8'($urandom); sseg = 7'($urandom);
    end
    chk("rst_value", value, 32'h0);
    chk("rst_err",   err_mask, 8'h0);
    chk("rst_fv",    n_fv, 0);
    @(negedge clk);
    an = '1; sseg = '1;
    #2 rst_n = 1'b1;
    show('1, '1, 5);

    // Encoder loopback
    f0 = n_fv;
    vals = '{1, 2, 3, 4, 10, 11, 12, 13};
    for (int k = 0; k < 8; k++) show(dig(k), enc(vals[k]), 16);
    show('1, '1, 8);
    chk("loop_frames", n_fv - f0, 1);
    chk("loop_value",  value, 32'hDCBA4321);
    chk("loop_err",    err_mask, 8'h00);
    chk("loop_model",  m_value, 32'hDCBA4321);

    // Glitch rejection on the last slot
    f0 = n_fv;
    for (int k = 0; k < 7; k++) show(dig(k), enc(k), 4);
    show(dig(7), enc(8), 3);
    show('1, '1, 10);
    chk("glitch_noframe", n_fv - f0, 0);
    show(dig(7), enc(5), 100);
    show('1, '1, 4);
    chk("glitch_frames", n_fv - f0, 1);
    chk("glitch_value",  value, 32'h56543210);

    // Illegal pattern, blanking and multi-low anodes
    f0 = n_fv;
    vals = '{7, 6, 5, 4, 3, -1, 1, 0};
    for (int k = 0; k < 8; k++) begin
      show(dig(k), (vals[k] < 0) ? 7'h7F : enc(vals[k]), 6);
      show('1, '1, 6);
      if (k == 2) show(8'h00, enc(8), 10);
    end
    chk("illegal_frames", n_fv - f0, 1);
    chk("illegal_value",  value, 32'h01034567);
    chk("illegal_err",    err_mask, 8'h20);
    chk("illegal_model",  m_err, 8'h20);

    // Overwrite with reverse order
    f0 = n_fv;
    show(dig(7), enc(7), 6); show(dig(6), enc(6), 6);
    show(dig(5), enc(5), 6); show(dig(4), enc(4), 6);
    show(dig(3), enc(9), 6); show(dig(2), enc(2), 6);
    show(dig(1), enc(1), 6); show(dig(3), enc(14), 6);
    show(dig(0), enc(0), 6);
    show('1, '1, 6);
    chk("ovr_frames", n_fv - f0, 1);
    chk("ovr_value",  value, 32'h7654E210);
    chk("ovr_err",    err_mask, 8'h00);

    // Partial frame then idle
    f0 = n_fv; t0 = n_to;
    for (int k = 0; k < 5; k++) show(dig(k), (k == 2) ? 7'h7F : enc(1), 6);
    show('1, '1, 120);
`ifdef SSEG_FRAME_TIMEOUT_EN
    chk("idle_timeouts", n_to - t0, 1);
`else
    chk("idle_timeouts", n_to - t0, 0);
`endif
    chk("idle_noframe", n_fv - f0, 0);
    for (int k = 0; k < 8; k++) show(dig(k), enc(15 - k), 6);
    show('1, '1, 6);
    chk("rescan_frames", n_fv - f0, 1);
    chk("rescan_value",  value, 32'h89ABCDEF);
    chk("rescan_err",    err_mask, 8'h00);

    // Randomized traffic with occasional asynchronous reset
    for (int it = 0; it < 600; it++) begin
      int r;
      logic [7:0] a;
      logic [6:0] s;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = dig(int'($urandom_range(0, 7)));
      else if (r == 7) a = '1;
      else             a = 8'($urandom);
      if ($urandom_range(0, 9) < 8) s = enc(int'($urandom_range(0, 15)));
      else                          s = 7'($urandom);
      show(a, s, int'($urandom_range(1, 10)));
      if (it % 150 == 149) begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    show('1, '1, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
